instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage that feeds the control unit and datapath decode.
//   - Holds the PC and issues one instruction-memory request at a time.
//   - Captures the returned word into an instruction register.
//   - Presents it to decode via a valid/ready handshake.
//   - Advances the PC, or redirects it to a branch target when decode signals PCSrc.
// PARAMETERS
//   XLEN      32            address/PC width
//   RESET_PC  32'h0000_0000 first fetch address after reset
//   NOP_INSTR 32'h0000_0013 instr value while empty/reset (addi x0,x0,0)
// PORTS
//   clk             in   1    single clock, rising edge
//   rst_n           in   1    asynchronous, active-low reset
//   imem_req        out  1    memory request valid
//   imem_addr       out  XLEN request address (word aligned)
//   imem_gnt        in   1    request accepted this cycle
//   imem_rvalid     in   1    read data valid
//   imem_rdata      in   32   read data
//   instr_valid     out  1    instr/pc outputs hold a fetched instruction
//   instr_ready     in   1    decode consumes the instruction this cycle
//   instr           out  32   instruction register
//   op              out  7    instr[6:0]
//   funct3          out  3    instr[14:12]
//   funct7_5        out  1    instr[30]
//   pc              out  XLEN address of instr
//   pc_plus4        out  XLEN pc + 4, modulo 2^XLEN
//   redirect        in   1    PCSrc for the presented instruction
//   redirect_target in   XLEN branch/jump target
//   fetch_misalign  out  1    sticky misaligned-target flag
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     state=S_REQ, fetch_pc=RESET_PC, imem_req=0, instr_valid=0,
//     instr=NOP_INSTR, pc=RESET_PC, fetch_misalign=0.
//   FSM states: S_REQ, S_WAIT, S_HOLD, S_TRAP.
//   S_REQ:
//     - imem_req=1, imem_addr=fetch_pc.
//     - Request and address stay stable until imem_gnt; then go to S_WAIT.
//     - imem_gnt in the same cycle as request assertion is legal.
//   S_WAIT:
//     - imem_req=0.
//     - On imem_rvalid: instr<=imem_rdata, pc<=fetch_pc, go to S_HOLD.
//   S_HOLD:
//     - instr_valid=1; instr, pc and the decoded fields are stable.
//     - On instr_ready: next fetch_pc = redirect ? redirect_target : pc+4;
//       instr_valid falls next cycle; go to S_REQ.
//   redirect and redirect_target are sampled only on an
//   instr_valid & instr_ready cycle; they are ignored otherwise.
//   imem_rvalid outside S_WAIT and imem_gnt outside S_REQ are ignored
//   (no state change).
//   Latency: gnt and rvalid in consecutive cycles gives instr_valid 1 cycle
//   after rvalid. Best-case throughput: 1 instruction per 3 cycles.
//   PC arithmetic wraps modulo 2^XLEN (32'hFFFF_FFFC + 4 = 0).
//   imem_addr[1:0] is always 2'b00.
//   rst_n asserted mid-request: the request is abandoned immediately.
//   A late rvalid after reset release arrives in S_REQ and is dropped.
// CONFIGURATION
//   Macro: IFU_MISALIGN_TRAP_EN.
//   Defined:
//     - A redirect accepted with redirect_target[1:0]!=0 enters S_TRAP.
//     - S_TRAP: fetch_misalign=1, imem_req=0, instr_valid=0.
//     - S_TRAP is left only by reset. pc holds the faulting target.
//   Undefined:
//     - redirect_target[1:0] is forced to 2'b00 and fetch continues.
//     - S_TRAP is unreachable; fetch_misalign is tied to 0.
// TESTING
//   1 Reset release, gnt in the first cycle, rvalid 1 cycle later with
//     rdata=32'h0020_8133 -> imem_addr=0, instr_valid=1, op=7'h33,
//     funct3=0, funct7_5=0, pc=0.
//   2 Three accepts, no redirect, instr_ready=1 -> imem_addr sequence
//     0,4,8; pc_plus4=4,8,C.
//   3 Accept with redirect=1, target=32'h40 -> next imem_addr=32'h40,
//     then pc=32'h40.
//   4 Hold gnt low 5 cycles, then instr_ready low 4 cycles in S_HOLD ->
//     imem_addr and instr/pc stable throughout, no extra request.
//   5 rst_n low during S_WAIT, rvalid arrives 1 cycle after release ->
//     data dropped, imem_addr=RESET_PC, instr=NOP_INSTR.
//   6 IFU_MISALIGN_TRAP_EN: accept redirect to 32'h42 -> fetch_misalign=1,
//     imem_req=0 until reset. Without macro: next imem_addr=32'h40.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, instruction register, valid/ready to decode.
// Define IFU_MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of masking them.
module instr_fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7_5,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            fetch_misalign
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_TRAP
    } state_t;

    state_t          r_state;
    logic            r_req;
    logic            r_valid;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_next_pc;
    logic            w_trap;

    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_target   = redirect_target & ~XLEN'(3);
    assign w_next_pc  = redirect ? w_target : w_pc_plus4;

`ifdef IFU_MISALIGN_TRAP_EN
    assign w_trap         = redirect && (redirect_target[1:0] != 2'b00);
    assign fetch_misalign = (r_state == S_TRAP);
`else
    assign w_trap         = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
        end else begin
            unique case (r_state)
                S_REQ: begin
                    // first cycle after reset raises the request; gnt counts only once it is up
                    if (r_req && imem_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_instr <= imem_rdata;
                        r_pc    <= r_fetch_pc;
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                        if (w_trap) begin
                            r_pc    <= redirect_target;
                            r_state <= S_TRAP;
                        end else begin
                            r_fetch_pc <= w_next_pc;
                            r_req      <= 1'b1;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign op          = r_instr[6:0];
    assign funct3      = r_instr[14:12];
    assign funct7_5    = r_instr[30];
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level model plus directed cases.
// Honours IFU_MISALIGN_TRAP_EN the same way as the design.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        fetch_misalign;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .op(op),
        .funct3(funct3),
        .funct7_5(funct7_5),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .fetch_misalign(fetch_misalign)
    );

    // model: address to fetch next, granted addresses awaiting data,
    // the instruction held for decode, and the trapped flag
    logic [31:0] m_next;
    logic [31:0] m_q[$];
    logic        m_have;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_trap;
    logic        m_first;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic exp_req();
        return !m_trap && !m_have && (m_q.size() == 0) && !m_first;
    endfunction

    task automatic model_reset();
        m_next  = RPC;
        m_q.delete();
        m_have  = 1'b0;
        m_instr = NOP;
        m_pc    = RPC;
        m_trap  = 1'b0;
        m_first = 1'b1;
    endtask

    task automatic compare();
        if (!rst_n) begin
            chk("rst_req", 32'(imem_req), 0);
            chk("rst_valid", 32'(instr_valid), 0);
            chk("rst_instr", instr, NOP);
            chk("rst_pc", pc, RPC);
            chk("rst_misalign", 32'(fetch_misalign), 0);
            return;
        end
        if (m_trap) begin
            chk("trap_flag", 32'(fetch_misalign), 1);
            chk("trap_req", 32'(imem_req), 0);
            chk("trap_valid", 32'(instr_valid), 0);
            chk("trap_pc", pc, m_pc);
            return;
        end
        chk("misalign", 32'(fetch_misalign), 0);
        chk("req", 32'(imem_req), 32'(exp_req()));
        if (exp_req()) chk("addr", imem_addr, m_next);
        chk("valid", 32'(instr_valid), 32'(m_have));
        if (m_have) begin
            chk("instr", instr, m_instr);
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("op", 32'(op), 32'(m_instr[6:0]));
            chk("funct3", 32'(funct3), 32'(m_instr[14:12]));
            chk("funct7_5", 32'(funct7_5), 32'(m_instr[30]));
        end else begin
            chk("empty_instr", instr, NOP);
        end
    endtask

    task automatic model_adv(input logic g, input logic v,
                             input logic [31:0] d, input logic rdy,
                             input logic rd, input logic [31:0] t);
        logic [31:0] a;
        if (m_first) begin
            m_first = 1'b0;
        end else if (exp_req() && g) begin
            m_q.push_back(m_next);
        end else if (m_q.size() != 0 && v) begin
            a = m_q.pop_front();
            m_have  = 1'b1;
            m_instr = d;
            m_pc    = a;
        end else if (m_have && rdy) begin
            m_have = 1'b0;
            if (!rd) begin
                m_next = m_pc + 32'd4;
            end else begin
`ifdef IFU_MISALIGN_TRAP_EN
                if (t[1:0] != 2'b00) begin
                    m_trap = 1'b1;
                    m_pc   = t;
                end else begin
                    m_next = t;
                end
`else
                m_next = {t[31:2], 2'b00};
`endif
            end
        end
    endtask

    task automatic step(input logic rv, input logic g, input logic v,
                        input logic [31:0] d, input logic rdy,
                        input logic rd, input logic [31:0] t);
        @(negedge clk);
        compare();
        rst_n           = rv;
        imem_gnt        = g;
        imem_rvalid     = v;
        imem_rdata      = d;
        instr_ready     = rdy;
        redirect        = rd;
        redirect_target = t;
        if (!rv) model_reset();
        else model_adv(g, v, d, rdy, rd, t);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_req(input logic g);
        int n;
        n = 0;
        do begin
            step(1, g, 0, 0, 0, 0, 0);
            n++;
        end while (!imem_req && n < 10);
        if (!imem_req) chk("req_timeout", 32'(imem_req), 1);
    endtask

    task automatic xact(input logic [31:0] d, input logic rd,
                        input logic [31:0] t, output logic [31:0] a,
                        output logic [31:0] p, output logic [31:0] p4);
        wait_req(1);
        a = imem_addr;
        step(1, 0, 1, d, 0, 0, 0);
        step(1, 0, 0, 0, 1, rd, t);
        chk("xact_valid", 32'(instr_valid), 1);
        p  = pc;
        p4 = pc_plus4;
    endtask

    logic [31:0] a, p, p4, a0, i0;

    initial begin
        model_reset();

        do_reset();
        wait_req(1);
        chk("t1_addr", imem_addr, 32'h0);
        step(1, 0, 1, 32'h0020_8133, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t1_valid", 32'(instr_valid), 1);
        chk("t1_op", 32'(op), 32'h33);
        chk("t1_f3", 32'(funct3), 0);
        chk("t1_f75", 32'(funct7_5), 0);
        chk("t1_pc", pc, 32'h0);

        do_reset();
        for (int k = 0; k < 3; k++) begin
            xact(32'h0000_0033 + k, 0, 0, a, p, p4);
            chk("t2_addr", a, 32'(4 * k));
            chk("t2_pc4", p4, 32'(4 * k + 4));
        end

        xact(32'h0000_0063, 1, 32'h40, a, p, p4);
        xact(32'h0000_0013, 0, 0, a, p, p4);
        chk("t3_addr", a, 32'h40);
        chk("t3_pc", p, 32'h40);

        do_reset();
        wait_req(0);
        a0 = imem_addr;
        repeat (5) step(1, 0, 0, 0, 0, 0, 0);
        chk("t4_addr", imem_addr, a0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'hABCD_E0B7, 0, 0, 0);
        repeat (4) begin
            step(1, 0, 0, 0, 0, 0, 0);
            chk("t4_instr", instr, 32'hABCD_E0B7);
            chk("t4_pc", pc, 32'h0);
            chk("t4_noreq", 32'(imem_req), 0);
        end
        step(1, 0, 0, 0, 1, 0, 0);

        wait_req(1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t5_instr", instr, NOP);
        chk("t5_valid", 32'(instr_valid), 0);
        chk("t5_addr", imem_addr, RPC);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);

        xact(32'h0000_006F, 1, 32'hFFFF_FFFC, a, p, p4);
        xact(32'h0000_0013, 0, 0, a, p, p4);
        chk("wrap_addr", a, 32'hFFFF_FFFC);
        chk("wrap_pc4", p4, 32'h0);
        xact(32'h0000_0013, 0, 0, a, p, p4);
        chk("wrap_next", a, 32'h0);

        xact(32'h0000_0063, 1, 32'h42, a, p, p4);
`ifdef IFU_MISALIGN_TRAP_EN
        repeat (4) begin
            step(1, 1, 1, 0, 1, 0, 0);
            chk("t6_flag", 32'(fetch_misalign), 1);
            chk("t6_req", 32'(imem_req), 0);
        end
        chk("t6_pc", pc, 32'h42);
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t6_clear", 32'(fetch_misalign), 0);
`else
        xact(32'h0000_0013, 0, 0, a, p, p4);
        chk("t6_addr", a, 32'h40);
        chk("t6_flag", 32'(fetch_misalign), 0);
`endif

        for (int c = 0; c < 3000; c++) begin
            logic        rv, g, v, rdy, rd;
            logic [31:0] d, t;
            rv  = ($urandom_range(0, 299) != 0);
            g   = ($urandom_range(0, 1) == 1);
            v   = ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 1) == 1);
            rd  = ($urandom_range(0, 3) == 0);
            d   = $urandom;
            t   = $urandom;
`ifdef IFU_MISALIGN_TRAP_EN
            t = {t[31:2], 2'b00};
`endif
            step(rv, g, v, d, rdy, rd, t);
        end
        step(1, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
